// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard unit for a five-stage in-order pipeline (F/D/E/M/W). It does four
// things:
//   * Operand forwarding into Execute from the Memory and Writeback stages.
//   * Load-use detection: it holds Fetch/Decode and bubbles Execute.
//   * Control-hazard flushing when a branch/jump resolves taken in Execute.
//   * Data-memory wait handling. The Memory stage raises a request and waits
//     for an acknowledge. While it waits, the whole front of the pipeline is
//     frozen. A bounded wait counter aborts the access after TIMEOUT cycles
//     and sets a sticky error flag.
//
// Memory handshake (MemReqM / MemReadyM):
//   MemReqM is held high by the Memory stage for as long as its access is
//   outstanding. The access completes in the cycle in which MemReqM and
//   MemReadyM are both high. Every cycle with MemReqM high and MemReadyM low
//   is a wait cycle, unless that cycle is the abort cycle. Dropping MemReqM
//   while waiting ends the wait without a timeout.
//
// Parameters:
//   TIMEOUT       number of wait cycles before abort, 1..255
//
// Ports:
//   clk           clock; all state updates happen on the rising edge
//   reset         synchronous, active-high reset
//   Rs1D, Rs2D    source registers of the instruction in Decode
//   Rs1E, Rs2E    source registers of the instruction in Execute
//   RdE           destination register of the instruction in Execute
//   ResultSrcE    result select in Execute; 2'b01 marks a load
//   PCSrcE        taken branch/jump resolved in Execute
//   RdM, RegWriteM  Memory-stage destination register and write enable
//   RdW, RegWriteW  Writeback-stage destination register and write enable
//   MemReqM       data-memory access outstanding in Memory
//   MemReadyM     data-memory acknowledge
//   StallF..StallM  hold the corresponding pipeline register
//   FlushD/E/W    load a bubble into the corresponding pipeline register
//   ForwardAE/BE  ALU operand select: 00 RF, 10 from M, 01 from W
//   MemTimeout    sticky memory-abort flag, cleared only by reset
//   StallCycles   saturating count of cycles with StallF high
//   FlushCount    saturating count of branch flushes
//   dbg_state     current FSM state (0 = RUN, 1 = MEM_WAIT)
//   dbg_wait_cnt  current memory wait counter
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  Rs1E,
   input  logic [4:0]  Rs2E,
   input  logic [4:0]  RdE,
   input  logic [1:0]  ResultSrcE,
   input  logic        PCSrcE,
   input  logic [4:0]  RdM,
   input  logic        RegWriteM,
   input  logic [4:0]  RdW,
   input  logic        RegWriteW,
   input  logic        MemReqM,
   input  logic        MemReadyM,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushW,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        MemTimeout,
   output logic [15:0] StallCycles,
   output logic [15:0] FlushCount,
   output logic        dbg_state,
   output logic [7:0]  dbg_wait_cnt
);

   // FSM encoding
   localparam logic [0:0] RUN      = 1'b0;
   localparam logic [0:0] MEM_WAIT = 1'b1;

   localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);
   localparam logic [15:0] CNT_MAX   = 16'hFFFF;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_M  = 2'b10;
   localparam logic [1:0] FWD_W  = 2'b01;

   logic [0:0]  state;
   logic [0:0]  state_nxt;
   logic [7:0]  wait_cnt;
   logic [7:0]  wait_cnt_nxt;

   logic        abort;
   logic        mem_stall;
   logic        lw_stall;
   logic        branch_flush;

   // -------------------------------------------------------------------------
   // Forwarding. The youngest producer (Memory) wins over Writeback. x0 is
   // never forwarded because it is hard-wired to zero in the register file.
   // -------------------------------------------------------------------------
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic       we_m,
      input logic [4:0] rd_w,
      input logic       we_w
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         sel = FWD_M;
      end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         sel = FWD_W;
      end
      return sel;
   endfunction

   // -------------------------------------------------------------------------
   // Hazard detection
   // -------------------------------------------------------------------------

   // The abort cycle is the one in which the counter has already reached
   // TIMEOUT and memory still has not acknowledged. A late acknowledge that
   // arrives on that same cycle completes the access normally.
   assign abort = (state == MEM_WAIT) && MemReqM && !MemReadyM &&
                  (wait_cnt == TIMEOUT_C);

   // The memory stall releases in the same cycle as the acknowledge or the
   // abort, so the pipeline advances without an extra bubble.
   assign mem_stall = MemReqM && !MemReadyM && !abort;

   assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

   // A frozen pipeline must not act on a branch. The branch is still in
   // Execute after the release and is acted on at that point.
   assign branch_flush = PCSrcE && !mem_stall;

   // -------------------------------------------------------------------------
   // Output decode. Reset forces a clean pipeline: nothing is held and every
   // stage register is bubbled.
   // -------------------------------------------------------------------------
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      if (!reset) begin
         ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
         ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
         StallF    = mem_stall || lw_stall;
         StallD    = mem_stall || lw_stall;
         StallE    = mem_stall;
         StallM    = mem_stall;
         FlushD    = branch_flush;
         // A load-use bubble into Execute is suppressed while memory stalls.
         // Execute is held in that case, so no bubble is needed.
         FlushE    = branch_flush || (lw_stall && !mem_stall);
         // Writeback gets a bubble while Memory is held. It also gets one on
         // the abort cycle, so that the failed access never retires.
         FlushW    = mem_stall || abort;
      end
   end

   // -------------------------------------------------------------------------
   // Memory wait FSM
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         RUN: begin
            if (mem_stall) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = 8'd1;
            end else begin
               wait_cnt_nxt = 8'd0;
            end
         end
         MEM_WAIT: begin
            if (mem_stall) begin
               // The count cannot pass TIMEOUT (max 255). The abort fires at
               // TIMEOUT and leaves this state.
               wait_cnt_nxt = wait_cnt + 8'd1;
            end else begin
               // Acknowledge, abort or withdrawn request
               state_nxt    = RUN;
               wait_cnt_nxt = 8'd0;
            end
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // The sticky error flag. Reset has priority, so resetting on the abort
   // cycle itself leaves the flag clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         MemTimeout <= 1'b0;
      end else if (abort) begin
         MemTimeout <= 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Performance counters (saturating)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         StallCycles <= 16'd0;
         FlushCount  <= 16'd0;
      end else begin
         if (StallF && (StallCycles != CNT_MAX)) begin
            StallCycles <= StallCycles + 16'd1;
         end
         if (branch_flush && (FlushCount != CNT_MAX)) begin
            FlushCount <= FlushCount + 16'd1;
         end
      end
   end

   assign dbg_state    = state[0];
   assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl, built with TIMEOUT = 4. Each call to step()
// drives one cycle of inputs just after a rising edge. It pushes the
// hand-written expected outputs for that cycle, plus the expected counter
// values, into exp_q. A monitor on the falling edge pops each entry and
// compares it against the DUT.
//
// Expected word layout (45 bits):
//   [44] StallF [43] StallD [42] StallE [41] StallM
//   [40] FlushD [39] FlushE [38] FlushW [37:36] ForwardAE [35:34] ForwardBE
//   [33] MemTimeout [32] dbg_state [31:16] StallCycles [15:0] FlushCount
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int W = 45;

   typedef struct {
      logic       rst;
      logic [4:0] rs1d;
      logic [4:0] rs2d;
      logic [4:0] rs1e;
      logic [4:0] rs2e;
      logic [4:0] rde;
      logic [1:0] rsrc;
      logic       pcsrc;
      logic [4:0] rdm;
      logic       rwm;
      logic [4:0] rdw;
      logic       rww;
      logic       mreq;
      logic       mrdy;
   } stim_t;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0;
   logic [1:0]  ResultSrcE = '0;
   logic        PCSrcE = 1'b0;
   logic [4:0]  RdM = '0, RdW = '0;
   logic        RegWriteM = 1'b0, RegWriteW = 1'b0;
   logic        MemReqM = 1'b0, MemReadyM = 1'b0;

   logic        StallF, StallD, StallE, StallM;
   logic        FlushD, FlushE, FlushW;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        MemTimeout;
   logic [15:0] StallCycles, FlushCount;
   logic        dbg_state;
   logic [7:0]  dbg_wait_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .Rs1D         (Rs1D),
      .Rs2D         (Rs2D),
      .Rs1E         (Rs1E),
      .Rs2E         (Rs2E),
      .RdE          (RdE),
      .ResultSrcE   (ResultSrcE),
      .PCSrcE       (PCSrcE),
      .RdM          (RdM),
      .RegWriteM    (RegWriteM),
      .RdW          (RdW),
      .RegWriteW    (RegWriteW),
      .MemReqM      (MemReqM),
      .MemReadyM    (MemReadyM),
      .StallF       (StallF),
      .StallD       (StallD),
      .StallE       (StallE),
      .StallM       (StallM),
      .FlushD       (FlushD),
      .FlushE       (FlushE),
      .FlushW       (FlushW),
      .ForwardAE    (ForwardAE),
      .ForwardBE    (ForwardBE),
      .MemTimeout   (MemTimeout),
      .StallCycles  (StallCycles),
      .FlushCount   (FlushCount),
      .dbg_state    (dbg_state),
      .dbg_wait_cnt (dbg_wait_cnt)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   logic [15:0]  sc_m = 16'd0;
   logic [15:0]  fc_m = 16'd0;
   stim_t        s;

   function automatic stim_t idle();
      stim_t t;
      t.rst = 1'b0;  t.rs1d = '0; t.rs2d = '0; t.rs1e = '0; t.rs2e = '0;
      t.rde = '0;    t.rsrc = '0; t.pcsrc = 1'b0; t.rdm = '0; t.rwm = 1'b0;
      t.rdw = '0;    t.rww = 1'b0; t.mreq = 1'b0; t.mrdy = 1'b0;
      return t;
   endfunction

   // Pack the hand-computed per-cycle expectation
   function automatic logic [12:0] ex(
      input logic sf, input logic sd, input logic se, input logic sm,
      input logic fd, input logic fe, input logic fw,
      input logic [1:0] fa, input logic [1:0] fb,
      input logic mt, input logic st
   );
      return {sf, sd, se, sm, fd, fe, fw, fa, fb, mt, st};
   endfunction

   function automatic logic [12:0] ex_quiet(input logic mt, input logic st);
      return ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, mt, st);
   endfunction

   function automatic logic [12:0] ex_mem(input logic mt, input logic st);
      return ex(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, mt, st);
   endfunction

   function automatic logic [12:0] ex_rst(input logic mt, input logic st);
      return ex(0, 0, 0, 0, 1, 1, 1, 2'b00, 2'b00, mt, st);
   endfunction

   // ---------------- driver ----------------
   task automatic step(input string nm, input logic [12:0] e);
      @(posedge clk);
      #1;
      reset      = s.rst;
      Rs1D       = s.rs1d;
      Rs2D       = s.rs2d;
      Rs1E       = s.rs1e;
      Rs2E       = s.rs2e;
      RdE        = s.rde;
      ResultSrcE = s.rsrc;
      PCSrcE     = s.pcsrc;
      RdM        = s.rdm;
      RegWriteM  = s.rwm;
      RdW        = s.rdw;
      RegWriteW  = s.rww;
      MemReqM    = s.mreq;
      MemReadyM  = s.mrdy;
      exp_q.push_back({e, sc_m, fc_m});
      name_q.push_back(nm);
      // Counters seen in the next cycle follow from this cycle's expected
      // StallF (e[12]) and from a branch not masked by a memory stall (e[9]).
      if (s.rst) begin
         sc_m = 16'd0;
         fc_m = 16'd0;
      end else begin
         if (e[12] && sc_m != 16'hFFFF) sc_m = sc_m + 16'd1;
         if (s.pcsrc && !e[9] && fc_m != 16'hFFFF) fc_m = fc_m + 16'd1;
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] got_v;
      string        nm;
      if (exp_q.size() != 0) begin
         exp_v = exp_q.pop_front();
         nm    = name_q.pop_front();
         got_v = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                  ForwardAE, ForwardBE, MemTimeout, dbg_state,
                  StallCycles, FlushCount};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got stall=%b flush=%b fwd=%b/%b mt=%b st=%b sc=%0d fc=%0d, expected stall=%b flush=%b fwd=%b/%b mt=%b st=%b sc=%0d fc=%0d",
                     nm, got_v[44:41], got_v[40:38], got_v[37:36], got_v[35:34],
                     got_v[33], got_v[32], got_v[31:16], got_v[15:0],
                     exp_v[44:41], exp_v[40:38], exp_v[37:36], exp_v[35:34],
                     exp_v[33], exp_v[32], exp_v[31:16], exp_v[15:0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset dominates arbitrary hazard inputs
      s = idle(); s.rst = 1; s.pcsrc = 1; s.mreq = 1; s.rsrc = 2'b01;
      s.rde = 3; s.rs1d = 3; s.rwm = 1; s.rdm = 5; s.rs1e = 5;
      step("reset_junk0", ex_rst(0, 0));
      step("reset_junk1", ex_rst(0, 0));
      s = idle();
      step("idle_after_reset", ex_quiet(0, 0));

      // Forwarding
      s = idle(); s.rwm = 1; s.rdm = 5; s.rww = 1; s.rdw = 5; s.rs1e = 5;
      step("fwd_m_priority", ex(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0));
      s.rdm = 0;
      step("fwd_w_when_rdm0", ex(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0));
      s = idle(); s.rwm = 1; s.rdm = 7; s.rww = 1; s.rdw = 9;
      s.rs1e = 9; s.rs2e = 7;
      step("fwd_a_w_b_m", ex(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0));
      s = idle(); s.rdm = 7; s.rdw = 7; s.rs1e = 7; s.rs2e = 7;
      step("fwd_no_write", ex_quiet(0, 0));
      s = idle(); s.rwm = 1; s.rww = 1; s.rs1e = 0; s.rs2e = 0;
      step("fwd_x0", ex_quiet(0, 0));

      // Load-use
      s = idle(); s.rsrc = 2'b01; s.rde = 3; s.rs2d = 3;
      step("lw_stall_rs2", ex(1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0));
      s.rsrc = 2'b00;
      step("not_a_load", ex_quiet(0, 0));
      s = idle(); s.rsrc = 2'b01; s.rde = 0; s.rs1d = 0;
      step("lw_rd_x0", ex_quiet(0, 0));
      s = idle(); s.rsrc = 2'b01; s.rde = 4; s.rs1d = 4;
      step("lw_stall_rs1", ex(1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0));

      // Branch flush
      s = idle(); s.pcsrc = 1;
      step("branch", ex(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0));
      s = idle();
      step("after_branch", ex_quiet(0, 0));
      s = idle(); s.pcsrc = 1; s.rsrc = 2'b01; s.rde = 2; s.rs1d = 2;
      step("branch_and_lw", ex(1, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0));
      s = idle(); s.pcsrc = 1; s.mreq = 1;
      step("branch_masked_by_mem", ex_mem(0, 0));
      s = idle(); s.mreq = 1; s.mrdy = 1;
      step("mem_ack_1wait", ex_quiet(0, 1));

      // Memory wait of 3 cycles from a fresh reset
      s = idle(); s.rst = 1;
      step("reset_before_wait", ex_rst(0, 0));
      s = idle(); s.mreq = 1;
      step("wait3_c1", ex_mem(0, 0));
      s.pcsrc = 1; s.rsrc = 2'b01; s.rde = 3; s.rs2d = 3;
      step("wait3_c2_mem_priority", ex_mem(0, 1));
      s = idle(); s.mreq = 1;
      step("wait3_c3", ex_mem(0, 1));
      s.mrdy = 1;
      step("wait3_ack", ex_quiet(0, 1));
      s = idle();
      step("wait3_run", ex_quiet(0, 0));

      // Acknowledge on the would-be abort cycle
      s = idle(); s.mreq = 1;
      step("race_c1", ex_mem(0, 0));
      step("race_c2", ex_mem(0, 1));
      step("race_c3", ex_mem(0, 1));
      step("race_c4", ex_mem(0, 1));
      s.mrdy = 1;
      step("race_ack_wins", ex_quiet(0, 1));
      s = idle();
      step("race_no_timeout", ex_quiet(0, 0));

      // Timeout
      s = idle(); s.mreq = 1;
      step("to_c1", ex_mem(0, 0));
      step("to_c2", ex_mem(0, 1));
      step("to_c3", ex_mem(0, 1));
      step("to_c4", ex_mem(0, 1));
      step("to_abort", ex(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1));
      s = idle();
      step("to_sticky", ex_quiet(1, 0));
      s.pcsrc = 1;
      step("to_sticky_branch", ex(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1, 0));

      // Reset mid-wait clears the flag and the counters
      s = idle(); s.mreq = 1;
      step("rw_c1", ex_mem(1, 0));
      step("rw_c2", ex_mem(1, 1));
      step("rw_c3", ex_mem(1, 1));
      s.rst = 1;
      step("rw_reset", ex_rst(1, 1));
      s = idle();
      step("rw_after_reset", ex_quiet(0, 0));

      // Reset on the abort cycle itself sets no timeout
      s = idle(); s.mreq = 1;
      step("ra_c1", ex_mem(0, 0));
      step("ra_c2", ex_mem(0, 1));
      step("ra_c3", ex_mem(0, 1));
      step("ra_c4", ex_mem(0, 1));
      s.rst = 1;
      step("ra_reset_at_abort", ex_rst(0, 1));
      s = idle();
      step("ra_after_reset", ex_quiet(0, 0));

      // Drain the scoreboard, bounded
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max data-memory wait cycles before abort (1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Rs1D, Rs2D  in  5 each  source registers of instruction in Decode.
REQ-005 Rs1E, Rs2E, RdE  in  5 each  source/dest registers in Execute.
REQ-006 ResultSrcE  in  2  result select in Execute; 2'b01 = load.
REQ-007 PCSrcE  in  1  taken branch/jump resolved in Execute.
REQ-008 RdM, RegWriteM  in  5/1  Memory-stage dest and write enable.
REQ-009 RdW, RegWriteW  in  5/1  Writeback-stage dest and write enable.
REQ-010 MemReqM, MemReadyM  in  1/1  data-memory access in Memory stage; memory ack.
REQ-011 StallF, StallD, StallE, StallM  out  1 each  hold stage pipeline register.
REQ-012 FlushD, FlushE, FlushW  out  1 each  bubble into stage pipeline register.
REQ-013 ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 RF, 10 from M, 01 from W.
REQ-014 MemTimeout  out  1  sticky memory-abort flag.
REQ-015 StallCycles, FlushCount  out  16 each  saturating performance counters.

Function
REQ-016 ForwardAE SHALL be 10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00; ForwardBE identically on Rs2E; combinational, zero latency.
REQ-017 lwStall = (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D); SHALL assert StallF, StallD, FlushE in the same cycle.
REQ-018 PCSrcE SHALL assert FlushD and FlushE in the same cycle.
REQ-019 memStall = MemReqM & ~MemReadyM & ~abort; SHALL assert StallF, StallD, StallE, StallM and FlushW.
REQ-020 Priority: memStall overrides all; while memStall, FlushD=FlushE=0 (branch/load-use re-evaluated after release).
REQ-021 FSM states RUN, MEM_WAIT; reset state RUN.
REQ-022 RUN -> MEM_WAIT when memStall; wait counter (8-bit) loads 1.
REQ-023 MEM_WAIT -> RUN when MemReadyM; stalls deassert in that same cycle (combinational on MemReadyM).
REQ-024 MEM_WAIT with ~MemReadyM: counter increments; abort = (state==MEM_WAIT) & (counter==TIMEOUT).
REQ-025 On abort cycle: stalls deassert, FlushW=1, MemTimeout set, FSM -> RUN; MemTimeout remains 1 until reset.
REQ-026 MemReadyM and abort in the same cycle: MemReadyM wins, no timeout.
REQ-027 StallCycles SHALL increment each cycle StallF=1, saturating at 16'hFFFF.
REQ-028 FlushCount SHALL increment each cycle PCSrcE=1 and memStall=0, saturating at 16'hFFFF.
REQ-029 All stall/flush/forward outputs are combinational from inputs and state; no added pipeline latency.

Reset
REQ-030 reset high at a clock edge: FSM=RUN, wait counter=0, MemTimeout=0, StallCycles=0, FlushCount=0.
REQ-031 While reset high: all Stall*=0, FlushD=FlushE=FlushW=1, ForwardAE=ForwardBE=00, regardless of other inputs.
REQ-032 Reset in MEM_WAIT SHALL abandon the wait with no MemTimeout set.

Verification
REQ-033 RegWriteM=1,RdM=5,RegWriteW=1,RdW=5,Rs1E=5,Rs2E=0 -> ForwardAE=10, ForwardBE=00; RdM=0 -> ForwardAE=01.
REQ-034 ResultSrcE=01,RdE=3,Rs2D=3 -> StallF=StallD=FlushE=1, FlushD=0, StallCycles +1 next edge.
REQ-035 PCSrcE=1 for 1 cycle -> FlushD=FlushE=1 that cycle, FlushCount=1; repeated with MemReqM=1,MemReadyM=0 -> no flush, FlushCount unchanged.
REQ-036 MemReqM=1, MemReadyM low 3 cycles then high -> Stall F/D/E/M=1 and FlushW=1 for 3 cycles, all 0 on 4th, FSM RUN, StallCycles=3.
REQ-037 TIMEOUT=4, MemReqM=1, MemReadyM=0 held -> stalls released on the 5th cycle with FlushW=1, MemTimeout=1 thereafter until reset.
REQ-038 reset asserted mid-MEM_WAIT -> next cycle RUN, counters 0, MemTimeout=0.
